// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Fetch/decode/execute controller for the 16-bit CPU. Each instruction is fetched
//   as two bytes (high byte first) over the 8-bit memory bus. The decoder is then
//   enabled for one cycle. An optional operand byte is fetched next, either inline
//   after the instruction or from RAM page zero. Finally one execute cycle issues
//   a single-cycle strobe to the datapath. The sequencer owns the program counter.
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   run                   allow a new instruction fetch to start
//   mem_req/addr/ack      byte read handshake; a transfer completes on req & ack
//   mem_rdata             read byte, valid with mem_ack
//   inst, data            instruction and operand byte registers (to decoder)
//   dec_en                decoder enable (DECODE and EXECUTE cycles)
//   inst_*, source_*, rhs decoder results
//   operand               datapath operand: RAM byte or decoder rhs
//   acc_load/acc_add/out_lo_stb  one-cycle execute strobes
//   pc                    program counter
//   busy                  instruction in flight or fetch requested
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] inst,
  output logic [7:0]  data,
  output logic        dec_en,
  input  logic        inst_nop,
  input  logic        inst_load,
  input  logic        inst_add,
  input  logic        inst_branch,
  input  logic        inst_out_lo,
  input  logic        source_imm,
  input  logic        source_ram,
  input  logic [15:0] rhs,
  output logic [15:0] operand,
  output logic        acc_load,
  output logic        acc_add,
  output logic        out_lo_stb,
  output logic [15:0] pc,
  output logic        busy
);

  typedef enum logic [2:0] {
    FETCH_HI,
    FETCH_LO,
    DECODE,
    OPERAND,
    EXECUTE
  } state_t;

  state_t state;
  logic   ram_op;     // operand byte comes from RAM page zero, not the inline stream
  logic   need_data;
  logic   xfer;
  logic   is_exec;
  logic   unused_dec;

  // Decoder flags are mutually exclusive; nop and source_imm need no action here.
  assign unused_dec = inst_nop ^ source_imm;

  assign need_data = (inst[15:14] == 2'b10) && (inst[10:9] == 2'b01);
  assign is_exec   = (state == EXECUTE);

  always_comb begin
    mem_req = 1'b0;
    unique case (state)
      FETCH_HI:          mem_req = run & ~rst;
      FETCH_LO, OPERAND: mem_req = 1'b1;
      default:           mem_req = 1'b0;
    endcase
  end

  assign mem_addr   = (state == OPERAND && ram_op) ? {8'h00, inst[7:0]} : pc;
  assign xfer       = mem_req & mem_ack;
  assign dec_en     = (state == DECODE) || is_exec;
  assign operand    = source_ram ? {8'h00, data} : rhs;
  // Priority keeps the strobes one-hot even if the decoder misbehaves.
  assign acc_load   = is_exec & inst_load;
  assign acc_add    = is_exec & inst_add & ~inst_load;
  assign out_lo_stb = is_exec & inst_out_lo & ~inst_load & ~inst_add;
  assign busy       = (state != FETCH_HI) || mem_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH_HI;
      pc     <= RESET_PC;
      inst   <= '0;
      data   <= '0;
      ram_op <= 1'b0;
    end else begin
      unique case (state)
        FETCH_HI: begin
          if (xfer) begin
            inst[15:8] <= mem_rdata;
            pc         <= pc + 16'd1;
            state      <= FETCH_LO;
          end
        end
        FETCH_LO: begin
          if (xfer) begin
            inst[7:0] <= mem_rdata;
            pc        <= pc + 16'd1;
            state     <= DECODE;
          end
        end
        DECODE: begin
          // Latched here because decoder outputs are not valid while dec_en=0.
          ram_op <= source_ram & ~need_data;
          state  <= (need_data || source_ram) ? OPERAND : EXECUTE;
        end
        OPERAND: begin
          if (xfer) begin
            data <= mem_rdata;
            if (!ram_op) pc <= pc + 16'd1;
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (inst_branch && !inst_load && !inst_add && !inst_out_lo)
            pc <= pc + rhs;
          state <= FETCH_HI;
        end
        default: state <= FETCH_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [15:0] inst;
  logic [7:0]  data;
  logic        dec_en;
  logic        inst_nop, inst_load, inst_add, inst_branch, inst_out_lo;
  logic        source_imm, source_ram;
  logic [15:0] rhs;
  logic [15:0] operand;
  logic        acc_load, acc_add, out_lo_stb;
  logic [15:0] pc;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] mpc;          // model program counter
  logic [15:0] last_operand;
  int          last_cyc;

  always #5 clk = ~clk;

  cpu_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst(inst), .data(data), .dec_en(dec_en),
    .inst_nop(inst_nop), .inst_load(inst_load), .inst_add(inst_add),
    .inst_branch(inst_branch), .inst_out_lo(inst_out_lo),
    .source_imm(source_imm), .source_ram(source_ram), .rhs(rhs),
    .operand(operand), .acc_load(acc_load), .acc_add(acc_add), .out_lo_stb(out_lo_stb),
    .pc(pc), .busy(busy)
  );

  // Stand-in instruction decoder.
  // op inst[15:14]: 00 nop (out_lo if inst[13]), 01 add, 10 load, 11 branch
  // src inst[10:9] (add/load): 10 ram page zero, 01 inline data byte (load only)
  always_comb begin
    inst_nop    = 1'b0;
    inst_load   = 1'b0;
    inst_add    = 1'b0;
    inst_branch = 1'b0;
    inst_out_lo = 1'b0;
    source_ram  = 1'b0;
    rhs         = {8'h00, inst[7:0]};
    case (inst[15:14])
      2'b00: if (inst[13]) inst_out_lo = 1'b1; else inst_nop = 1'b1;
      2'b01: inst_add = 1'b1;
      2'b10: inst_load = 1'b1;
      default: inst_branch = 1'b1;
    endcase
    if ((inst_add || inst_load) && inst[10:9] == 2'b10) source_ram = 1'b1;
    if (inst_load && inst[10:9] == 2'b01) rhs = inst[8] ? {data, 8'h00} : {8'h00, data};
    if (inst_branch) rhs = {{8{inst[7]}}, inst[7:0]};
    source_imm = ~source_ram;
  end

  // Runs one instruction from mpc, acting as the memory, and checks it against
  // the instruction-level meaning of the bytes in mem.
  task automatic run_and_check_inst(input int max_wait, input bit rand_wait, input bit rand_run);
    logic [15:0] ins, np, exp_op, ea [3];
    logic [7:0]  ob;
    logic [1:0]  op, src;
    logic        e_load, e_add, e_out;
    int nbytes, byte_i, wait_left, sum_w, dec_cnt, cyc;
    bit fire, last, done;
    ins = {mem[mpc], mem[mpc + 16'd1]};
    ea[0] = mpc; ea[1] = mpc + 16'd1; ea[2] = '0;
    np = mpc + 16'd2;
    nbytes = 2;
    op = ins[15:14]; src = ins[10:9];
    if (op == 2'b10 && src == 2'b01) begin
      ea[2] = np; ob = mem[np]; np = np + 16'd1; nbytes = 3;
      exp_op = ins[8] ? {ob, 8'h00} : {8'h00, ob};
    end else if ((op == 2'b01 || op == 2'b10) && src == 2'b10) begin
      ea[2] = {8'h00, ins[7:0]}; nbytes = 3;
      exp_op = {8'h00, mem[ea[2]]};
    end else if (op == 2'b11) begin
      exp_op = {{8{ins[7]}}, ins[7:0]};
    end else begin
      exp_op = {8'h00, ins[7:0]};
    end
    e_load = (op == 2'b10);
    e_add  = (op == 2'b01);
    e_out  = (op == 2'b00) && ins[13];
    if (op == 2'b11) np = np + exp_op;

    byte_i = 0; dec_cnt = 0; cyc = 0; last = 0; done = 0;
    wait_left = rand_wait ? $urandom_range(0, max_wait) : max_wait;
    sum_w = wait_left;
    for (int c = 0; c < 400 && !done; c++) begin
      run = (!rand_run || byte_i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      fire = 0;
      if (mem_req) begin
        total++;
        if (byte_i >= nbytes) begin
          bad++; $display("FAIL extra_req: addr=%h after %0d bytes", mem_addr, byte_i);
        end else if (mem_addr !== ea[byte_i]) begin
          bad++; $display("FAIL mem_addr: got %h want %h (byte %0d)", mem_addr, ea[byte_i], byte_i);
        end
        if (wait_left == 0) begin
          mem_ack = 1'b1; mem_rdata = mem[mem_addr]; fire = 1;
        end else begin
          mem_ack = 1'b0; mem_rdata = 8'($urandom); wait_left--;
        end
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = 8'($urandom);
      end
      if (dec_en) dec_cnt++;
      if (dec_en && dec_cnt == 2) begin
        last = 1;
        total++;
        if ({acc_load, acc_add, out_lo_stb} !== {e_load, e_add, e_out}) begin
          bad++; $display("FAIL strobes: got %b want %b inst=%h", {acc_load, acc_add, out_lo_stb},
                          {e_load, e_add, e_out}, ins);
        end
        total++;
        if (operand !== exp_op) begin
          bad++; $display("FAIL operand: got %h want %h inst=%h", operand, exp_op, ins);
        end
        total++;
        if (inst !== ins || byte_i != nbytes) begin
          bad++; $display("FAIL exec_inst: inst=%h want %h bytes=%0d want %0d", inst, ins, byte_i, nbytes);
        end
        last_operand = operand;
      end else begin
        total++;
        if ({acc_load, acc_add, out_lo_stb} !== 3'b000) begin
          bad++; $display("FAIL stray_strobe: got %b want 000", {acc_load, acc_add, out_lo_stb});
        end
      end
      @(posedge clk);
      cyc++;
      if (fire) begin
        byte_i++;
        if (byte_i < nbytes) begin
          wait_left = rand_wait ? $urandom_range(0, max_wait) : max_wait;
          sum_w += wait_left;
        end
      end
      if (last) done = 1;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    total++;
    if (!done) begin
      bad++; $display("FAIL timeout: inst=%h got no execute want execute", ins);
    end
    total++;
    if (pc !== np) begin
      bad++; $display("FAIL pc: got %h want %h inst=%h", pc, np, ins);
    end
    total++;
    if (cyc != nbytes + sum_w + 2) begin
      bad++; $display("FAIL cycles: got %0d want %0d inst=%h", cyc, nbytes + sum_w + 2, ins);
    end
    last_cyc = cyc;
    mpc = np;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({mem_req, dec_en, acc_load, acc_add, out_lo_stb, busy} !== 6'b0 ||
        pc !== 16'h0000 || inst !== 16'h0000 || data !== 8'h00) begin
      bad++; $display("FAIL reset_state: req/dec/strb/busy=%b pc=%h inst=%h data=%h want 0",
                      {mem_req, dec_en, acc_load, acc_add, out_lo_stb, busy}, pc, inst, data);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    mem_ack = 1'b1; mem_rdata = 8'hAB;
    @(negedge clk);
    #1;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0001 || inst[15:8] !== 8'hAB) begin
      bad++; $display("FAIL fetch_lo: req=%b addr=%h inst=%h want 1 0001 AB--", mem_req, mem_addr, inst);
    end
    mem_rdata = 8'hCD;     // ack pending for the low byte
    #2 rst = 1'b1;
    #1;
    total++;
    if ({mem_req, dec_en, acc_load, acc_add, out_lo_stb} !== 5'b0 || pc !== 16'h0000 ||
        inst !== 16'h0000) begin
      bad++; $display("FAIL reset_midfetch: outs=%b pc=%h inst=%h want 0 0000 0000",
                      {mem_req, dec_en, acc_load, acc_add, out_lo_stb}, pc, inst);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || {acc_load, acc_add, out_lo_stb} !== 3'b0) begin
      bad++; $display("FAIL refetch: req=%b addr=%h want 1 0000", mem_req, mem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mpc = 16'h0000;
  endtask

  task automatic test_load_imm();
    run_and_check_inst(0, 0, 0);
    total++;
    if (pc !== 16'h0002 || last_operand !== 16'h0012 || last_cyc != 4) begin
      bad++; $display("FAIL load_imm: pc=%h op=%h cyc=%0d want 0002 0012 4", pc, last_operand, last_cyc);
    end
  endtask

  task automatic test_load_data();
    run_and_check_inst(0, 0, 0);
    total++;
    if (pc !== 16'h0005 || last_operand !== 16'h0034 || last_cyc != 5) begin
      bad++; $display("FAIL load_data: pc=%h op=%h cyc=%0d want 0005 0034 5", pc, last_operand, last_cyc);
    end
    run_and_check_inst(0, 0, 0);
    total++;
    if (last_operand !== 16'h3400) begin
      bad++; $display("FAIL load_data_hi: op=%h want 3400", last_operand);
    end
    run_and_check_inst(0, 0, 0);   // add from RAM page zero
    total++;
    if (last_operand !== 16'h005A || pc !== 16'h000A) begin
      bad++; $display("FAIL add_ram: op=%h pc=%h want 005A 000A", last_operand, pc);
    end
    run_and_check_inst(0, 0, 0);   // out_lo
    run_and_check_inst(0, 0, 0);   // nop
  endtask

  task automatic test_branch();
    run_and_check_inst(0, 0, 0);   // C0 00 at 000E: falls to 0010
    run_and_check_inst(0, 0, 0);   // C7 FE: self-loop
    run_and_check_inst(0, 0, 0);
    total++;
    if (pc !== 16'h0010) begin
      bad++; $display("FAIL branch_loop: pc=%h want 0010", pc);
    end
    mem[16'h0010] = 8'hC0; mem[16'h0011] = 8'h04;
    run_and_check_inst(0, 0, 0);
    total++;
    if (pc !== 16'h0016) begin
      bad++; $display("FAIL branch_fwd: pc=%h want 0016", pc);
    end
  endtask

  task automatic test_wait_states();
    run_and_check_inst(3, 0, 0);
    total++;
    if (last_cyc != 10 || last_operand !== 16'h0099) begin
      bad++; $display("FAIL wait_states: cyc=%0d op=%h want 10 0099", last_cyc, last_operand);
    end
  endtask

  task automatic test_wrap_idle();
    run_and_check_inst(0, 0, 0);   // C0 E5 at 0018 -> FFFF
    total++;
    if (pc !== 16'hFFFF) begin
      bad++; $display("FAIL to_ffff: pc=%h want FFFF", pc);
    end
    mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h00;
    run_and_check_inst(0, 0, 0);
    total++;
    if (pc !== 16'h0001) begin
      bad++; $display("FAIL wrap: pc=%h want 0001", pc);
    end
    run = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (mem_req !== 1'b0 || busy !== 1'b0 || pc !== 16'h0001) begin
        bad++; $display("FAIL idle: req=%b busy=%b pc=%h want 0 0 0001", mem_req, busy, pc);
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_random();
    rst = 1'b1;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    @(negedge clk);
    rst = 1'b0;
    mpc = 16'h0000;
    for (int n = 0; n < 300; n++) run_and_check_inst(3, 1, 1);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    {mem[16'h0000], mem[16'h0001]} = 16'h8012;
    {mem[16'h0002], mem[16'h0003], mem[16'h0004]} = 24'h820034;
    {mem[16'h0005], mem[16'h0006], mem[16'h0007]} = 24'h830034;
    {mem[16'h0008], mem[16'h0009]} = 16'h4430;
    mem[16'h0030] = 8'h5A;
    {mem[16'h000A], mem[16'h000B]} = 16'h2000;
    {mem[16'h000C], mem[16'h000D]} = 16'h0000;
    {mem[16'h000E], mem[16'h000F]} = 16'hC000;
    {mem[16'h0010], mem[16'h0011]} = 16'hC7FE;
    {mem[16'h0016], mem[16'h0017]} = 16'h8099;
    {mem[16'h0018], mem[16'h0019]} = 16'hC0E5;
    test_reset();
    test_load_imm();
    test_load_data();
    test_branch();
    test_wait_states();
    test_wrap_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
